// File: rtl/branch_resolve_predict_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_predict_pkg
//   Shared definitions for the branch resolve / predict block:
//     - br_op_e   : 3-bit branch-op encoding carried down to EX
//     - ctr_init(): weakly-not-taken reset value for a counter of a given width
// -----------------------------------------------------------------------------
package branch_resolve_predict_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLEZ = 3'b011,
        BR_BGTZ = 3'b100
    } br_op_e;

    // Weakly-not-taken: the largest value whose MSB is still 0.
    // For a 1-bit counter this collapses to 0.
    function automatic int unsigned ctr_init(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_resolve_predict_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   WIDTH-bit saturating up/down counter with synchronous active-low reset
//   to INIT. One instance is one entry of the branch history table.
//
//   Ports:
//     clk_i    in   clock, rising edge
//     rst_ni   in   synchronous active-low reset (loads INIT)
//     en_i     in   count this cycle
//     up_i     in   1 = increment, 0 = decrement
//     count_o  out  current counter value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned          WIDTH = 2,
    parameter logic [WIDTH-1:0]     INIT  = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Saturate at both ends; never wrap.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            if (up_i) begin
                if (count_q != {WIDTH{1'b1}}) count_d = count_q + 1'b1;
            end else begin
                if (count_q != {WIDTH{1'b0}}) count_d = count_q - 1'b1;
            end
        end
    end

    // Reset wins over a pending enable.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) count_q <= INIT;
        else         count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/branch_resolve_predict.sv
// -----------------------------------------------------------------------------
// branch_resolve_predict
//   Resolves BEQ/BNE/BLEZ/BGTZ in EX, drives the PC-mux branch select, and
//   keeps a PC-indexed table of saturating counters that predicts taken /
//   not-taken for the instruction being fetched.
//
//   Optional build macro: BRANCH_STATS_EN adds stat_branches and
//   stat_mispredicts (32-bit saturating event counters).
//
//   Ports:
//     clk            in   clock, rising edge
//     reset          in   synchronous active-low reset
//     if_pc          in   PC being fetched
//     pred_taken     out  prediction for if_pc (combinational, no bypass)
//     ex_valid       in   EX holds a valid instruction
//     ex_stall       in   EX frozen this cycle
//     ex_branch_op   in   br_op_e encoding; unknown codes act as BR_NONE
//     ex_zero        in   ALU result == 0
//     ex_negative    in   ALU result sign bit
//     ex_pc          in   PC of the instruction in EX
//     ex_pred_taken  in   prediction that travelled with the branch
//     branch_taken   out  resolved outcome (branch mux select)
//     mispredict     out  IF/ID flush request
//     stat_branches     out  (BRANCH_STATS_EN) count of table updates
//     stat_mispredicts  out  (BRANCH_STATS_EN) count of mispredicts
//
//   EX qualification: a branch resolves whenever ex_valid is high and the op
//   is legal, so branch_taken is live even under a stall. It only "commits"
//   (table update, mispredict, stats) in a cycle where ex_stall is low, so a
//   branch held for several cycles is counted exactly once.
// -----------------------------------------------------------------------------
module branch_resolve_predict
    import branch_resolve_predict_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned CTR_WIDTH   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] if_pc,
    output logic                pred_taken,
    input  logic                ex_valid,
    input  logic                ex_stall,
    input  logic [2:0]          ex_branch_op,
    input  logic                ex_zero,
    input  logic                ex_negative,
    input  logic [PC_WIDTH-1:0] ex_pc,
    input  logic                ex_pred_taken,
    output logic                branch_taken,
    output logic                mispredict
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam int unsigned IDX = $clog2(BHT_ENTRIES);
    localparam logic [CTR_WIDTH-1:0] CTR_RST = CTR_WIDTH'(ctr_init(CTR_WIDTH));

    generate
        if (BHT_ENTRIES < 2 || (BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) begin : g_bad_entries
            $error("BHT_ENTRIES must be a power of two and at least 2");
        end
        if (CTR_WIDTH < 1 || CTR_WIDTH > 4) begin : g_bad_ctr
            $error("CTR_WIDTH must be in 1..4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Resolution
    // ------------------------------------------------------------------
    br_op_e op;
    logic   op_valid;
    logic   outcome;
    logic   commit;

    assign op = br_op_e'(ex_branch_op);

    always_comb begin
        op_valid = 1'b0;
        outcome  = 1'b0;
        case (op)
            BR_BEQ:  begin op_valid = 1'b1; outcome = ex_zero;                 end
            BR_BNE:  begin op_valid = 1'b1; outcome = !ex_zero;                end
            BR_BLEZ: begin op_valid = 1'b1; outcome = ex_zero | ex_negative;   end
            BR_BGTZ: begin op_valid = 1'b1; outcome = !ex_zero & !ex_negative; end
            default: begin op_valid = 1'b0; outcome = 1'b0;                    end
        endcase
    end

    assign branch_taken = ex_valid & op_valid & outcome;
    assign commit       = ex_valid & op_valid & !ex_stall;
    assign mispredict   = commit & (branch_taken != ex_pred_taken);

    // ------------------------------------------------------------------
    // Counter table
    // ------------------------------------------------------------------
    logic [IDX-1:0]                        if_idx;
    logic [IDX-1:0]                        ex_idx;
    logic [BHT_ENTRIES-1:0][CTR_WIDTH-1:0] ctr_val;

    // Word-aligned PCs: the two low bits never select an entry.
    assign if_idx = if_pc[IDX+1:2];
    assign ex_idx = ex_pc[IDX+1:2];

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        sat_counter #(
            .WIDTH (CTR_WIDTH),
            .INIT  (CTR_RST)
        ) u_ctr (
            .clk_i   (clk),
            .rst_ni  (reset),
            .en_i    (commit && (ex_idx == IDX'(i))),
            .up_i    (branch_taken),
            .count_o (ctr_val[i])
        );
    end

    // Reads see the registered value only; a same-cycle update to the same
    // entry becomes visible on the next cycle.
    assign pred_taken = ctr_val[if_idx][CTR_WIDTH-1];

    // Bits that intentionally play no part in indexing or prediction.
    logic unused_bits;
    assign unused_bits = ^{if_pc[1:0], if_pc[PC_WIDTH-1:IDX+2],
                           ex_pc[1:0], ex_pc[PC_WIDTH-1:IDX+2], ctr_val};

`ifdef BRANCH_STATS_EN
    // ------------------------------------------------------------------
    // Event counters, saturating at all-ones
    // ------------------------------------------------------------------
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (commit && stat_br_q != 32'hFFFF_FFFF)     stat_br_d = stat_br_q + 32'd1;
        if (mispredict && stat_mp_q != 32'hFFFF_FFFF) stat_mp_d = stat_mp_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_predict.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_predict
//   Table-driven bench: each record is one cycle of inputs plus the expected
//   combinational outputs sampled 1 time unit after the falling edge, before
//   the rising edge that commits any update. Default parameters: 16 entries,
//   2-bit counters, reset value 01.
// -----------------------------------------------------------------------------
module tb_branch_resolve_predict;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_stall;
    logic [2:0]  ex_branch_op;
    logic        ex_zero;
    logic        ex_negative;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        branch_taken;
    logic        mispredict;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_resolve_predict #(
        .PC_WIDTH    (32),
        .BHT_ENTRIES (16),
        .CTR_WIDTH   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .ex_valid      (ex_valid),
        .ex_stall      (ex_stall),
        .ex_branch_op  (ex_branch_op),
        .ex_zero       (ex_zero),
        .ex_negative   (ex_negative),
        .ex_pc         (ex_pc),
        .ex_pred_taken (ex_pred_taken),
        .branch_taken  (branch_taken),
        .mispredict    (mispredict)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // ---------------- vectors ----------------
    typedef struct {
        logic        rst_n;
        logic [31:0] ipc;
        logic        v;
        logic        st;
        logic [2:0]  op;
        logic        z;
        logic        n;
        logic [31:0] epc;
        logic        pin;
        logic        e_pred;
        logic        e_bt;
        logic        e_mp;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int passed = 0;
    int exp_br = 0;
    int exp_mp = 0;

    localparam logic [31:0] B = 32'h0040_0000;

    function automatic vec_t mk(logic rst_n, logic [31:0] ipc, logic v, logic st,
                                logic [2:0] op, logic z, logic n, logic [31:0] epc,
                                logic pin, logic e_pred, logic e_bt, logic e_mp);
        vec_t r;
        r.rst_n = rst_n; r.ipc = ipc; r.v = v; r.st = st; r.op = op; r.z = z;
        r.n = n; r.epc = epc; r.pin = pin; r.e_pred = e_pred; r.e_bt = e_bt;
        r.e_mp = e_mp;
        return r;
    endfunction

    // ---------------- driver / checker ----------------
    task automatic check1(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %0b expected %0b", name, idx, act, exp);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        reset         = t.rst_n;
        if_pc         = t.ipc;
        ex_valid      = t.v;
        ex_stall      = t.st;
        ex_branch_op  = t.op;
        ex_zero       = t.z;
        ex_negative   = t.n;
        ex_pc         = t.epc;
        ex_pred_taken = t.pin;
        #1;
        check1("pred_taken",   idx, pred_taken,   t.e_pred);
        check1("branch_taken", idx, branch_taken, t.e_bt);
        check1("mispredict",   idx, mispredict,   t.e_mp);
        // Event model for the optional statistics counters.
        if (!t.rst_n) begin
            exp_br = 0;
            exp_mp = 0;
        end else if (t.v && !t.st && t.op >= 3'd1 && t.op <= 3'd4) begin
            exp_br++;
            if (t.e_mp) exp_mp++;
        end
    endtask

    task automatic run_queue();
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
        vecs.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_stall = 1'b0;
        ex_branch_op = 3'd0; ex_zero = 1'b0; ex_negative = 1'b0;
        ex_pc = '0; ex_pred_taken = 1'b0;
        repeat (2) @(posedge clk);

        //            rst ipc       v  st op    z  n  epc       pin  pred bt mp
        // reset state
        vecs.push_back(mk(1, B+32'h00, 0, 0, 3'd0, 0, 0, B,        0,   0, 0, 0));
        vecs.push_back(mk(1, B+32'h3C, 0, 0, 3'd0, 0, 0, B,        0,   0, 0, 0));
        // BEQ taken at idx2, predicted not-taken: 01 -> 10
        vecs.push_back(mk(1, B+32'h00, 1, 0, 3'd1, 1, 0, B+32'h08, 0,   0, 1, 1));
        vecs.push_back(mk(1, B+32'h08, 0, 0, 3'd0, 0, 0, B,        0,   1, 0, 0));
        // three more taken: 10 -> 11 -> 11 -> 11
        vecs.push_back(mk(1, B+32'h08, 1, 0, 3'd1, 1, 0, B+32'h08, 1,   1, 1, 0));
        vecs.push_back(mk(1, B+32'h08, 1, 0, 3'd1, 1, 0, B+32'h08, 1,   1, 1, 0));
        vecs.push_back(mk(1, B+32'h08, 1, 0, 3'd1, 1, 0, B+32'h08, 1,   1, 1, 0));
        // one not-taken: 11 -> 10, still predicts taken
        vecs.push_back(mk(1, B+32'h08, 1, 0, 3'd1, 0, 0, B+32'h08, 1,   1, 0, 1));
        vecs.push_back(mk(1, B+32'h08, 0, 0, 3'd0, 0, 0, B,        0,   1, 0, 0));
        // BLEZ negative at idx4, read same idx same cycle -> old value
        vecs.push_back(mk(1, B+32'h10, 1, 0, 3'd3, 0, 1, B+32'h10, 0,   0, 1, 1));
        // BGTZ with zero at idx5 -> not taken; idx4 now 10
        vecs.push_back(mk(1, B+32'h10, 1, 0, 3'd4, 1, 0, B+32'h14, 0,   1, 0, 0));
        // illegal op 111 at idx6: no outcome, no flush, no update
        vecs.push_back(mk(1, B+32'h14, 1, 0, 3'd7, 0, 0, B+32'h18, 1,   0, 0, 0));
        // taken BNE at idx6 proves it was still 01 (01 -> 10)
        vecs.push_back(mk(1, B+32'h18, 1, 0, 3'd2, 0, 0, B+32'h18, 0,   0, 1, 1));
        vecs.push_back(mk(1, B+32'h18, 0, 0, 3'd0, 0, 0, B,        0,   1, 0, 0));
        // remaining outcome cases
        vecs.push_back(mk(1, B+32'h20, 1, 0, 3'd2, 1, 0, B+32'h20, 1,   0, 0, 1));
        vecs.push_back(mk(1, B+32'h20, 1, 0, 3'd4, 0, 0, B+32'h24, 1,   0, 1, 0));
        vecs.push_back(mk(1, B+32'h24, 1, 0, 3'd3, 1, 0, B+32'h28, 1,   1, 1, 0));
        vecs.push_back(mk(1, B+32'h28, 1, 0, 3'd3, 0, 0, B+32'h2C, 0,   1, 0, 0));
        // ex_valid low gates the outcome
        vecs.push_back(mk(1, B+32'h2C, 0, 0, 3'd1, 1, 0, B+32'h30, 0,   0, 0, 0));
        run_queue();

        // Stalled taken BNE at idx12: two stalled cycles, then release.
        vecs.push_back(mk(1, B+32'h30, 1, 1, 3'd2, 0, 0, B+32'h30, 0,   0, 1, 0));
        vecs.push_back(mk(1, B+32'h30, 1, 1, 3'd2, 0, 0, B+32'h30, 0,   0, 1, 0));
        vecs.push_back(mk(1, B+32'h30, 1, 0, 3'd2, 0, 0, B+32'h30, 0,   0, 1, 1));
        vecs.push_back(mk(1, B+32'h30, 0, 0, 3'd0, 0, 0, B,        0,   1, 0, 0));
        // One decrement brings a single-increment entry back below the MSB.
        vecs.push_back(mk(1, B+32'h30, 1, 0, 3'd1, 0, 0, B+32'h30, 0,   1, 0, 0));
        vecs.push_back(mk(1, B+32'h30, 0, 0, 3'd0, 0, 0, B,        0,   0, 0, 0));
        run_queue();

`ifdef BRANCH_STATS_EN
        #1;
        check32("stat_branches",    stat_branches,    32'(exp_br));
        check32("stat_mispredicts", stat_mispredicts, 32'(exp_mp));
`endif

        // Mid-stream reset with a taken BEQ to idx0 pending: it is discarded.
        vecs.push_back(mk(0, B+32'h08, 1, 0, 3'd1, 1, 0, B+32'h00, 0,   1, 1, 1));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1, B + 32'(i * 4), 0, 0, 3'd0, 0, 0, B, 0, 0, 0, 0));
        run_queue();

`ifdef BRANCH_STATS_EN
        check32("stat_branches_rst",    stat_branches,    32'(exp_br));
        check32("stat_mispredicts_rst", stat_mispredicts, 32'(exp_mp));
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Absolute run-time bound.
    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
